// File: rtl/gnn_pkg.sv
// Shared types and constants for the GNN output collector.
package gnn_pkg;
    localparam int GNN_NODES = 4;
    localparam int GNN_OUT_W = 21;

    typedef logic [1:0] node_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } gnn_state_e;
endpackage

// File: rtl/gnn_sat.sv
// Combinational signed clamp from IN_W to OUT_W bits; zero latency, no flow control.
module gnn_sat #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_dat,
    output logic signed [OUT_W-1:0] o_dat
);
    generate
        if (IN_W > OUT_W) begin : g_clamp
            // Representable iff every bit above the output sign bit matches it.
            logic [IN_W-OUT_W:0] w_top;
            logic                w_ovf;

            assign w_top = i_dat[IN_W-1:OUT_W-1];
            assign w_ovf = !((&w_top) || !(|w_top));

            always_comb begin
                o_dat = i_dat[OUT_W-1:0];
                if (w_ovf) begin
                    o_dat = i_dat[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                          : {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
        end else begin : g_pass
            assign o_dat = OUT_W'(i_dat);
        end
    endgenerate
endmodule

// File: rtl/gnn_out_collector.sv
// Captures the eight GNN node results when a job completes and streams them as four node beats (optional clamp: GNN_OUT_SAT_EN).
// First beat one cycle after capture, one beat per cycle at best; beats hold stable while m_ready is low.
module gnn_out_collector
    import gnn_pkg::*;
#(
    parameter int IN_W    = GNN_OUT_W,
    parameter int OUT_W   = 16,
    parameter int MIN_LAT = 3,
    parameter int TIMEOUT = 15,
`ifdef GNN_OUT_SAT_EN
    localparam int DW     = OUT_W
`else
    localparam int DW     = IN_W
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_ready,
    input  logic signed [IN_W-1:0] out0_node0,
    input  logic signed [IN_W-1:0] out0_node1,
    input  logic signed [IN_W-1:0] out0_node2,
    input  logic signed [IN_W-1:0] out0_node3,
    input  logic signed [IN_W-1:0] out1_node0,
    input  logic signed [IN_W-1:0] out1_node1,
    input  logic signed [IN_W-1:0] out1_node2,
    input  logic signed [IN_W-1:0] out1_node3,
    input  logic                 out10_ready_node0,
    input  logic                 out10_ready_node1,
    input  logic                 out10_ready_node2,
    input  logic                 out10_ready_node3,
    input  logic                 out11_ready_node0,
    input  logic                 out11_ready_node1,
    input  logic                 out11_ready_node2,
    input  logic                 out11_ready_node3,
    output logic                 m_valid,
    input  logic                 m_ready,
    output node_id_t             m_node_id,
    output logic signed [DW-1:0] m_out0,
    output logic signed [DW-1:0] m_out1,
    output logic                 m_class,
    output logic                 m_last,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int               WCW       = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0]   MIN_LAT_C = WCW'(MIN_LAT);
    localparam logic [WCW-1:0]   TMO_C     = WCW'(TIMEOUT);
    localparam node_id_t         LAST_ID   = node_id_t'(GNN_NODES - 1);

    if (MIN_LAT > TIMEOUT || OUT_W < 2) begin : g_cfg_check
        $error("gnn_out_collector: need MIN_LAT <= TIMEOUT and OUT_W >= 2");
    end

    gnn_state_e             r_state;
    gnn_state_e             w_next;
    logic [WCW-1:0]         r_wcnt;
    node_id_t               r_idx;
    logic                   r_timeout_err;
    logic signed [IN_W-1:0] r_buf0 [GNN_NODES];
    logic signed [IN_W-1:0] r_buf1 [GNN_NODES];
    logic signed [IN_W-1:0] w_in0  [GNN_NODES];
    logic signed [IN_W-1:0] w_in1  [GNN_NODES];
    logic                   w_all_rdy;
    logic                   w_capture;
    logic                   w_timeout;
    logic                   w_hs;
    logic                   w_last_hs;
    logic                   w_enter_wait;
    logic signed [IN_W-1:0] w_sel0;
    logic signed [IN_W-1:0] w_sel1;
    logic signed [DW-1:0]   w_dw0;
    logic signed [DW-1:0]   w_dw1;

    assign w_in0[0] = out0_node0;
    assign w_in0[1] = out0_node1;
    assign w_in0[2] = out0_node2;
    assign w_in0[3] = out0_node3;
    assign w_in1[0] = out1_node0;
    assign w_in1[1] = out1_node1;
    assign w_in1[2] = out1_node2;
    assign w_in1[3] = out1_node3;

    assign w_all_rdy = &{out10_ready_node0, out10_ready_node1, out10_ready_node2, out10_ready_node3,
                         out11_ready_node0, out11_ready_node1, out11_ready_node2, out11_ready_node3};

    assign w_hs      = m_valid && m_ready;
    assign w_last_hs = w_hs && (r_idx == LAST_ID);

    // A repeated start strobe in WAIT restarts the latency window, so it outranks capture.
    assign w_capture = (r_state == WAIT) && !in_ready && w_all_rdy && (r_wcnt >= MIN_LAT_C);
    assign w_timeout = (r_state == WAIT) && !in_ready && !w_capture && (r_wcnt == TMO_C);

    // Start strobes mid-stream are dropped; only the final handshake may chain into a new job.
    assign w_enter_wait = in_ready && ((r_state != SEND) || w_last_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_ready) w_next = WAIT;
            WAIT: begin
                if (w_capture)      w_next = SEND;
                else if (w_timeout) w_next = IDLE;
            end
            SEND:    if (w_last_hs) w_next = in_ready ? WAIT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        m_valid = (r_state == SEND);
        busy    = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt        <= '0;
            r_timeout_err <= 1'b0;
            r_idx         <= '0;
            for (int i = 0; i < GNN_NODES; i++) begin
                r_buf0[i] <= '0;
                r_buf1[i] <= '0;
            end
        end else begin
            if (w_enter_wait) begin
                r_wcnt <= '0;
            end else if ((r_state == WAIT) && (r_wcnt != TMO_C)) begin
                r_wcnt <= r_wcnt + WCW'(1);
            end

            if (w_enter_wait) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end

            if (w_capture) begin
                r_idx  <= '0;
                r_buf0 <= w_in0;
                r_buf1 <= w_in1;
            end else if (w_hs) begin
                r_idx <= r_idx + node_id_t'(1);
            end
        end
    end

    assign w_sel0 = r_buf0[r_idx];
    assign w_sel1 = r_buf1[r_idx];

`ifdef GNN_OUT_SAT_EN
    gnn_sat #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat0 (.i_dat(w_sel0), .o_dat(w_dw0));
    gnn_sat #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat1 (.i_dat(w_sel1), .o_dat(w_dw1));
`else
    assign w_dw0 = w_sel0;
    assign w_dw1 = w_sel1;
`endif

    assign m_out0      = w_dw0;
    assign m_out1      = w_dw1;
    assign m_class     = (w_dw1 > w_dw0);
    assign m_node_id   = r_idx;
    assign m_last      = m_valid && (r_idx == LAST_ID);
    assign timeout_err = r_timeout_err;
endmodule

// File: doc/gnn_out_collector.md
# gnn_out_collector

Downstream stage of the 4-node GNN top. It watches the eight `outX_node*` results and their `out1X_ready_node*` flags, and captures all eight results into a local buffer once a job is complete. It then streams them out as four valid/ready beats (node 0..3), each carrying both outputs plus an argmax class bit. A wait-state watchdog flags jobs whose ready flags never assert.

## Interface
Parameters:
- `IN_W`: default 21. Width of the signed GNN output words.
- `OUT_W`: default 16. Signed width of the saturated stream words (used only with `GNN_OUT_SAT_EN`).
- `MIN_LAT`: default 3. Cycles after `in_ready` before ready flags are trusted. This masks stale flags left over from the previous job.
- `TIMEOUT`: default 15. Maximum cycles spent in WAIT.

Ports:
- `clk` in, 1 bit: the single clock. All state updates on its rising edge.
- `rst_n` in, 1 bit: asynchronous, active-low reset.
- `in_ready` in, 1 bit: the same job-start strobe that drives the GNN top.
- `out0_node0`..`out0_node3` in, IN_W each, signed: output 0 per node.
- `out1_node0`..`out1_node3` in, IN_W each, signed: output 1 per node.
- `out10_ready_node0`..`out10_ready_node3` in, 1 bit each: ready flag for output 0.
- `out11_ready_node0`..`out11_ready_node3` in, 1 bit each: ready flag for output 1.
- `m_valid` out, 1 bit: stream beat valid.
- `m_ready` in, 1 bit: stream consumer ready.
- `m_node_id` out, 2 bits: node index of the current beat.
- `m_out0` out, DW bits, signed: output 0 of the current node.
- `m_out1` out, DW bits, signed: output 1 of the current node.
- `m_class` out, 1 bit: 1 iff `m_out1 > m_out0` (signed compare); a tie gives 0.
- `m_last` out, 1 bit: high on the node-3 beat.
- `busy` out, 1 bit: high in any state other than IDLE.
- `timeout_err` out, 1 bit: sticky watchdog flag.

DW is OUT_W with `GNN_OUT_SAT_EN` defined and IN_W without it.

## Operation
- `all_rdy` is the AND of all eight ready flags.
- FSM states: IDLE, WAIT, SEND.
- IDLE:
  - `in_ready` moves to WAIT.
  - On entry to WAIT, `wcnt` is cleared to 0 and `timeout_err` is cleared.
- WAIT:
  - `wcnt` increments by 1 each cycle and saturates at TIMEOUT.
  - `in_ready` seen again clears `wcnt` and keeps the state WAIT.
  - Capture when `all_rdy` is high and `wcnt >= MIN_LAT`. Capture latches all eight words into the buffer, sets `idx` to 0, and moves to SEND.
  - If `wcnt == TIMEOUT` without a capture: set `timeout_err`, go to IDLE, and emit no beats.
- SEND:
  - The beat for node `idx` is presented from registered buffer contents.
  - On `m_valid && m_ready`, `idx` increments.
  - On the `idx == 3` handshake, go to IDLE. If `in_ready` is high in that same cycle, go straight to WAIT instead.
  - `in_ready` at any other point in SEND is ignored. The buffer is never overwritten mid-stream.
- Node order is fixed: 0, 1, 2, 3.
- `m_class` is computed from the stream words after saturation, when saturation is compiled in.

## Timing
- Reset values: `m_valid`, `m_node_id`, `m_out0`, `m_out1`, `m_class`, `m_last`, `busy` and `timeout_err` are all 0. The state is IDLE.
- `rst_n` asserted mid-SEND drops `m_valid` immediately (asynchronously) and discards the buffer.
- Capture edge C: `m_valid` rises at C+1 with node 0.
- Minimum cost is one beat per cycle; with `m_ready` held high, the four beats occupy C+1..C+4.
- Under backpressure (`m_valid=1`, `m_ready=0`), all `m_*` outputs hold stable.
- `busy` rises the cycle after `in_ready` is sampled in IDLE. It falls the cycle after the final handshake or after a timeout.
- Flags toggling after capture have no effect.

## Configuration
- With `GNN_OUT_SAT_EN`:
  - Each buffered word is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] before output.
  - Example: with OUT_W=16, 40000 becomes 32767 and -40000 becomes -32768.
- Without `GNN_OUT_SAT_EN`:
  - DW = IN_W and words pass through unchanged.
  - No saturator logic is present.

## Structure
- Package `gnn_pkg`:
  - `gnn_state_e` enum (IDLE/WAIT/SEND).
  - `GNN_NODES = 4`.
  - `GNN_OUT_W = 21`.
  - `node_id_t` (2-bit typedef).
- Sub-module `gnn_sat`:
  - Combinational signed clamp, parameterised by IN_W and OUT_W.
  - Instantiated twice (for `m_out0` and `m_out1`) under `GNN_OUT_SAT_EN`.

## Test plan
- Basic job:
  - Stimulus: `in_ready` pulse; all flags high at `wcnt=3`; node0 outputs (5,-2), node1 (-7,9), node2 (0,0), node3 (100,101); `m_ready=1`.
  - Required: four beats on consecutive cycles with `m_class` = 0,1,0,1; `m_last` only on node 3.
- Stale flags:
  - Stimulus: flags already high when `in_ready` arrives.
  - Required: no capture before `wcnt=3`; the captured values are those present at `wcnt=3`.
- Backpressure:
  - Stimulus: `m_ready` low for 5 cycles on node 1.
  - Required: node-1 outputs stable throughout; node 2 follows one cycle after `m_ready` rises.
- Timeout:
  - Stimulus: one flag held low.
  - Required: `timeout_err=1` after 15 WAIT cycles; `busy` falls; no beats. The next `in_ready` clears `timeout_err`.
- Saturation (`GNN_OUT_SAT_EN`):
  - Stimulus: node0 out0=40000, out1=-40000.
  - Required: `m_out0=32767`, `m_out1=-32768`, `m_class=0`.
- Reset mid-SEND:
  - Stimulus: `rst_n` low during the node-2 beat.
  - Required: all outputs 0 at once; after release the block is in IDLE; the next job streams correctly from node 0.
